// File: rtl/score_keeper_pkg.sv
// Shared sizing constants and FSM state type for the score keeper.
package score_keeper_pkg;

    localparam int SCORE_W      = 8;
    localparam int BCD_DIGITS   = 3;
    localparam int SHIFT_CYCLES = 8;
    localparam int DD_W         = SCORE_W + 4 * BCD_DIGITS;
    localparam int CNT_W        = $clog2(SHIFT_CYCLES);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/score_keeper_bcd_adjust.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_adjust (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/score_keeper.sv
// Saturating game score with high-score tracking and a sequential
// binary-to-BCD converter that refreshes the display digits after each change.
module score_keeper
    import score_keeper_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               inc,
    input  logic               clear,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [3:0]         val_2,
    output logic [3:0]         val_1,
    output logic [3:0]         val_0,
    output logic               valid
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(SHIFT_CYCLES - 1);

    logic [SCORE_W-1:0]         next_score;
    logic                       score_event;
    state_t                     state;
    state_t                     state_next;
    logic                       dirty;
    logic [CNT_W-1:0]           count;
    logic [DD_W-1:0]            dd_reg;
    logic [DD_W-1:0]            dd_shifted;
    logic [BCD_DIGITS-1:0][3:0] adj_nib;
    logic                       load;
    logic                       shift_en;
    logic                       done;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_score  = score;
        score_event = 1'b0;
        if (clear) begin
            next_score  = '0;
            score_event = 1'b1;
        end else if (inc && score != SCORE_MAX) begin
            next_score  = score + 1'b1;
            score_event = 1'b1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            score      <= '0;
            high_score <= '0;
        end else begin
            score <= next_score;
            if (next_score > high_score)
                high_score <= next_score;
        end
    end

    // A change on the load edge re-arms dirty, since the loaded value is stale.
    always_ff @(posedge clk) begin
        if (!resetn)
            dirty <= 1'b0;
        else if (score_event)
            dirty <= 1'b1;
        else if (load)
            dirty <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dirty) state_next = SHIFT;
            SHIFT:   if (count == LAST_COUNT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load     = (state == IDLE) && dirty;
        shift_en = (state == SHIFT);
        done     = (state == SHIFT) && (count == LAST_COUNT);
        valid    = (state == IDLE) && !dirty;
    end

    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
        bcd_adjust u_adj (
            .nibble   (dd_reg[SCORE_W + 4*d +: 4]),
            .adjusted (adj_nib[d])
        );
    end

    assign dd_shifted = {adj_nib, dd_reg[SCORE_W-1:0]} << 1;

    // NOTE: the conversion register is always loaded before it is read, so it
    // carries no reset; only the control state and visible outputs do.
    always_ff @(posedge clk) begin
        if (load)
            dd_reg <= DD_W'(score);
        else if (shift_en)
            dd_reg <= dd_shifted;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
            val_2 <= '0;
            val_1 <= '0;
            val_0 <= '0;
        end else begin
            if (load)
                count <= '0;
            else if (shift_en)
                count <= count + 1'b1;
            if (done) begin
                val_2 <= dd_shifted[SCORE_W + 8 +: 4];
                val_1 <= dd_shifted[SCORE_W + 4 +: 4];
                val_0 <= dd_shifted[SCORE_W     +: 4];
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed and randomized bench for score_keeper, checked against an
// arithmetic model of score, high score and decimal digits.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       inc = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] score;
    logic [7:0] high_score;
    logic [3:0] val_2;
    logic [3:0] val_1;
    logic [3:0] val_0;
    logic       valid;

    int checks = 0;
    int errors = 0;
    int m_score = 0;
    int m_high = 0;
    bit mon_en = 1'b0;

    score_keeper dut (
        .clk        (clk),
        .resetn     (resetn),
        .inc        (inc),
        .clear      (clear),
        .score      (score),
        .high_score (high_score),
        .val_2      (val_2),
        .val_1      (val_1),
        .val_0      (val_0),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [11:0] bcd_of(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_vals(input string tag, input logic [11:0] exp);
        check(tag, {20'd0, val_2, val_1, val_0}, {20'd0, exp});
    endtask

    // One clock edge with the given pulses; the model follows the game rules.
    task automatic step(input logic i, input logic c);
        inc   = i;
        clear = c;
        @(posedge clk);
        if (c)
            m_score = 0;
        else if (i && m_score < 255)
            m_score = m_score + 1;
        if (m_score > m_high)
            m_high = m_score;
        #1;
        inc   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (valid !== 1'b1 && n < 40) begin
            step(1'b0, 1'b0);
            n++;
        end
        check(tag, {31'd0, valid}, 32'd1);
    endtask

    // Whenever the digits are claimed valid they must match the model score.
    always @(negedge clk) begin
        if (mon_en && valid === 1'b1)
            check("mon_vals", {20'd0, val_2, val_1, val_0}, {20'd0, bcd_of(m_score)});
    end

    initial begin
        // Reset held for two edges.
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn  = 1'b1;
        m_score = 0;
        m_high  = 0;
        check("rst_score", score, 0);
        check("rst_high", high_score, 0);
        check_vals("rst_vals", 12'h000);
        check("rst_valid", valid, 1);
        mon_en = 1'b1;

        // Single increment: exact conversion latency.
        step(1'b1, 1'b0);
        check("one_score", score, 1);
        check("one_valid_e1", valid, 0);
        for (int e = 2; e <= 9; e++) begin
            step(1'b0, 1'b0);
            check($sformatf("one_valid_e%0d", e), valid, 0);
        end
        step(1'b0, 1'b0);
        check("one_valid_e10", valid, 1);
        check_vals("one_vals", 12'h001);
        check("one_high", high_score, 1);

        // Ramp to 9, then a second inc arrives mid-conversion.
        repeat (8) begin
            step(1'b1, 1'b0);
            wait_valid("ramp9_valid");
        end
        check("ramp9_score", score, m_score);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        check_vals("mid_vals_e10", 12'h010);
        check("mid_valid_e10", valid, 0);
        repeat (8) step(1'b0, 1'b0);
        check("mid_valid_e18", valid, 0);
        step(1'b0, 1'b0);
        check_vals("mid_vals_e19", 12'h011);
        check("mid_valid_e19", valid, 1);

        // Clear and inc together at 42: clear wins, high score kept.
        repeat (31) step(1'b1, 1'b0);
        wait_valid("ramp42_valid");
        check("ramp42_score", score, 42);
        check("ramp42_high", high_score, 42);
        check_vals("ramp42_vals", 12'h042);
        step(1'b1, 1'b1);
        check("clr_score", score, 0);
        check("clr_high", high_score, 42);
        check("clr_valid_e1", valid, 0);
        repeat (9) step(1'b0, 1'b0);
        check("clr_valid_e10", valid, 1);
        check_vals("clr_vals", 12'h000);

        // Reset on edge 5 of a conversion, with inc also asserted.
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        resetn = 1'b0;
        inc    = 1'b1;
        @(posedge clk);
        m_score = 0;
        m_high  = 0;
        #1;
        resetn = 1'b1;
        inc    = 1'b0;
        check("mrst_score", score, 0);
        check("mrst_high", high_score, 0);
        check_vals("mrst_vals", 12'h000);
        check("mrst_valid", valid, 1);
        repeat (20) step(1'b0, 1'b0);
        check_vals("mrst_vals_late", 12'h000);
        check("mrst_valid_late", valid, 1);

        // Randomized pulses against the model.
        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 15));
            step(r < 7, r == 0);
            check("rnd_score", score, m_score);
            check("rnd_high", high_score, m_high);
            if (k % 50 == 49) begin
                wait_valid("rnd_valid");
                check_vals("rnd_vals", bcd_of(m_score));
            end
        end

        // Full ramp to saturation, each step converted.
        resetn = 1'b0;
        @(posedge clk);
        m_score = 0;
        m_high  = 0;
        #1;
        resetn = 1'b1;
        for (int n = 1; n <= 255; n++) begin
            step(1'b1, 1'b0);
            wait_valid("sat_ramp_valid");
        end
        check("sat_score", score, 255);
        check("sat_high", high_score, 255);
        check_vals("sat_vals", 12'h255);
        step(1'b1, 1'b0);
        check("sat_score_after", score, 255);
        check("sat_valid_e1", valid, 1);
        repeat (11) begin
            step(1'b0, 1'b0);
            check("sat_valid_hold", valid, 1);
        end
        check_vals("sat_vals_after", 12'h255);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
